// File: rtl/div_if.sv
// Divider request/response bundle between execute (master) and the div sequencer (slave).
// Latency: n/a (wires only).
// Backpressure: the slave raises div_stall; the master holds its pipeline while it is high.
//
// Ports:
//   master : drives div_start/div_op/div_word/div_rs1/div_rs2/div_rd/flush,
//            observes div_busy/div_stall/div_done/div_result/div_rd_out
//   slave  : the mirror image of master
interface div_if #(
  parameter int XLEN = 64,
  parameter int RDW  = 6
);
  logic            div_start;
  logic [1:0]      div_op;
  logic            div_word;
  logic [XLEN-1:0] div_rs1;
  logic [XLEN-1:0] div_rs2;
  logic [RDW-1:0]  div_rd;
  logic            flush;
  logic            div_busy;
  logic            div_stall;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic [RDW-1:0]  div_rd_out;

  modport master (
    output div_start, div_op, div_word, div_rs1, div_rs2, div_rd, flush,
    input  div_busy, div_stall, div_done, div_result, div_rd_out
  );

  modport slave (
    input  div_start, div_op, div_word, div_rs1, div_rs2, div_rd, flush,
    output div_busy, div_stall, div_done, div_result, div_rd_out
  );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle divide/remainder unit (div, divu, rem, remu and their W forms), restoring radix-2.
// Latency: div_done 1 cycle after accept for divide-by-zero / signed overflow, N+1 cycles otherwise.
// Backpressure: div_stall holds execute/decode while a request is accepted or CALC is running.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : div_if slave modport (request operands, flush, busy/stall/done/result/tag)
module div_sequencer #(
  parameter int XLEN = 64,
  parameter int RDW  = 6
) (
  input logic  clk,
  input logic  reset,
  div_if.slave bus
);

  // Counter holds N itself (up to XLEN), so it needs log2(XLEN)+1 bits.
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] N_FULL = CW'(XLEN);
  localparam logic [CW-1:0] N_WORD = CW'(32);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;   // dividend shifts out of the top, quotient bits shift in at the bottom
  logic [XLEN-1:0] rem_q, rem_d;   // partial remainder
  logic [XLEN-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [XLEN-1:0] res_q, res_d;
  logic [RDW-1:0]  rd_q, rd_d;
  logic [RDW-1:0]  rdo_q, rdo_d;
  logic            is_rem_q, is_rem_d;
  logic            word_q, word_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;

  // Apply sign correction and the W sign-extension to a raw quotient/remainder pair.
  function automatic logic [XLEN-1:0] finalize(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic            is_rem,
    input logic            word,
    input logic            nq,
    input logic            nr
  );
    logic [XLEN-1:0] v;
    v = is_rem ? (nr ? -r : r) : (nq ? -q : q);
    if (word) v = {{(XLEN-32){v[31]}}, v[31:0]};
    return v;
  endfunction

  // ---------------------------------------------------------------
  // Operand preparation for a request presented this cycle
  // ---------------------------------------------------------------
  logic            signed_op;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] most_neg;
  logic            div_zero, sgn_ovf;
  logic            accept;

  assign signed_op = ~bus.div_op[0];

  always_comb begin
    a_ext = bus.div_rs1;
    b_ext = bus.div_rs2;
    if (bus.div_word) begin
      a_ext = signed_op ? {{(XLEN-32){bus.div_rs1[31]}}, bus.div_rs1[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.div_rs1[31:0]};
      b_ext = signed_op ? {{(XLEN-32){bus.div_rs2[31]}}, bus.div_rs2[31:0]}
                        : {{(XLEN-32){1'b0}}, bus.div_rs2[31:0]};
    end
  end

  assign sign_a = signed_op & a_ext[XLEN-1];
  assign sign_b = signed_op & b_ext[XLEN-1];
  assign mag_a  = sign_a ? -a_ext : a_ext;
  assign mag_b  = sign_b ? -b_ext : b_ext;

  // Most-negative value of width N, as it appears after sign extension.
  assign most_neg = bus.div_word ? {{(XLEN-31){1'b1}}, 31'b0}
                                 : {1'b1, {(XLEN-1){1'b0}}};

  assign div_zero = (b_ext == '0);
  assign sgn_ovf  = signed_op && (b_ext == '1) && (a_ext == most_neg);

  // Flush kills a same-cycle request; CALC ignores requests entirely.
  assign accept = bus.div_start && !bus.flush && (state_q != S_CALC);

  // ---------------------------------------------------------------
  // One restoring-division step
  // ---------------------------------------------------------------
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] rem_step, quo_step;

  assign trial    = {rem_q, quo_q[XLEN-1]};
  assign fits     = (trial >= {1'b0, dvs_q});
  // Remainder stays below the divisor, so the low XLEN bits of the difference are exact.
  assign rem_step = fits ? (trial[XLEN-1:0] - dvs_q) : trial[XLEN-1:0];
  assign quo_step = {quo_q[XLEN-2:0], fits};

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    rd_d     = rd_q;
    rdo_d    = rdo_q;
    is_rem_d = is_rem_q;
    word_d   = word_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            is_rem_d = bus.div_op[1];
            word_d   = bus.div_word;
            rd_d     = bus.div_rd;
            negq_d   = sign_a ^ sign_b;
            negr_d   = sign_a;
            if (div_zero || sgn_ovf) begin
              // Result is known immediately; no iterations needed.
              state_d = S_DONE;
              cnt_d   = '0;
              res_d   = finalize(div_zero ? '1 : a_ext,
                                 div_zero ? a_ext : '0,
                                 bus.div_op[1], bus.div_word, 1'b0, 1'b0);
              rdo_d   = bus.div_rd;
            end else begin
              state_d = S_CALC;
              cnt_d   = bus.div_word ? N_WORD : N_FULL;
              // Left-align a W dividend so its MSB is always consumed from the top bit.
              quo_d   = bus.div_word ? (mag_a << 32) : mag_a;
              rem_d   = '0;
              dvs_d   = mag_b;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = S_DONE;
            res_d   = finalize(quo_step, rem_step, is_rem_q, word_q, negq_q, negr_q);
            rdo_d   = rd_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      rdo_q    <= '0;
      is_rem_q <= 1'b0;
      word_q   <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      rd_q     <= rd_d;
      rdo_q    <= rdo_d;
      is_rem_q <= is_rem_d;
      word_q   <= word_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  assign bus.div_busy   = (state_q != S_IDLE);
  assign bus.div_done   = (state_q == S_DONE);
  assign bus.div_stall  = (bus.div_start && (state_q == S_IDLE || state_q == S_DONE))
                        || (state_q == S_CALC);
  assign bus.div_result = res_q;
  assign bus.div_rd_out = rdo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (XLEN=64, RDW=6).
// Drives and samples on the falling edge; every expected value is hand-computed.
// Covers reset, normal/special latency, W ops, back-to-back, flush and mid-CALC reset.
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  div_if #(.XLEN(64), .RDW(6)) bus();

  div_sequencer #(.XLEN(64), .RDW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request; caller is positioned just after a falling edge.
  task automatic start_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [5:0] rd);
    bus.div_start = 1'b1;
    bus.div_op    = op;
    bus.div_word  = w;
    bus.div_rs1   = a;
    bus.div_rs2   = b;
    bus.div_rd    = rd;
  endtask

  // Follow an accepted request to its div_done cycle, scrambling inputs afterwards.
  // With poke set, a stray request is issued during CALC and must be ignored.
  task automatic finish_op(input string tag, input logic [63:0] exp_res, input logic [5:0] exp_rd,
                           input int exp_lat, input bit poke);
    int cyc;
    int stall_cnt;
    int idle_cnt;
    #1;
    stall_cnt = bus.div_stall ? 1 : 0;
    idle_cnt  = 0;
    @(negedge clk);
    bus.div_start = 1'b0;
    bus.div_op    = ~bus.div_op;
    bus.div_word  = ~bus.div_word;
    bus.div_rs1   = ~bus.div_rs1;
    bus.div_rs2   = bus.div_rs2 ^ 64'h5A5A_0F0F_3C3C_9696;
    bus.div_rd    = ~bus.div_rd;
    cyc = 1;
    while (cyc < 200) begin
      bus.div_start = poke && (cyc == 5);
      #1;
      if (bus.div_done === 1'b1) break;
      if (bus.div_stall === 1'b1) stall_cnt++;
      if (bus.div_busy !== 1'b1) idle_cnt++;
      @(negedge clk);
      cyc++;
    end
    bus.div_start = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_result"}, bus.div_result, exp_res);
    check({tag, "_rd_out"}, 64'(bus.div_rd_out), 64'(exp_rd));
    check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
    check({tag, "_busy_gaps"}, 64'(idle_cnt), 64'd0);
    check({tag, "_stall_in_done"}, 64'(bus.div_stall), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [5:0] rd,
                        input logic [63:0] exp_res, input int exp_lat, input bit poke);
    @(negedge clk);
    start_op(op, w, a, b, rd);
    finish_op(tag, exp_res, rd, exp_lat, poke);
    @(negedge clk);
    #1;
    check({tag, "_done_pulse_end"}, 64'(bus.div_done), 64'd0);
    check({tag, "_idle_after"}, 64'(bus.div_busy), 64'd0);
  endtask

  // Watch for a bounded number of cycles and count any div_done.
  task automatic count_done(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (bus.div_done === 1'b1) dones++;
    end
  endtask

  initial begin
    int dones;
    n_tests = 0;
    n_fail  = 0;
    reset         = 1'b0;
    bus.div_start = 1'b0;
    bus.div_op    = 2'b00;
    bus.div_word  = 1'b0;
    bus.div_rs1   = '0;
    bus.div_rs2   = '0;
    bus.div_rd    = '0;
    bus.flush     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",   64'(bus.div_busy),   64'd0);
    check("rst_stall",  64'(bus.div_stall),  64'd0);
    check("rst_done",   64'(bus.div_done),   64'd0);
    check("rst_result", bus.div_result,      64'd0);
    check("rst_rd_out", 64'(bus.div_rd_out), 64'd0);

    // First request presented in the same cycle reset is released
    @(negedge clk);
    reset = 1'b1;
    start_op(OP_DIV, 1'b0, 64'd100, 64'd7, 6'd5);
    finish_op("div_100_7", 64'd14, 6'd5, 65, 1'b0);
    @(negedge clk);
    #1;
    check("div_100_7_done_pulse_end", 64'(bus.div_done), 64'd0);

    run_op("rem_m100_7", OP_REM, 1'b0, -64'sd100, 64'd7, 6'd11, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);
    run_op("div_100_m7", OP_DIV, 1'b0, 64'd100, -64'sd7, 6'd12, 64'hFFFF_FFFF_FFFF_FFF2, 65, 1'b0);
    run_op("divu_by0",   OP_DIVU, 1'b0, 64'd5, 64'd0, 6'd20, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run_op("remu_by0",   OP_REMU, 1'b0, 64'd5, 64'd0, 6'd21, 64'd5, 1, 1'b0);
    run_op("div_ovf",    OP_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd22,
           64'h8000_0000_0000_0000, 1, 1'b0);
    run_op("rem_ovf",    OP_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'd23,
           64'd0, 1, 1'b0);
    run_op("divw",       OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 6'd30,
           64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b0);
    run_op("divuw_ones", OP_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 6'd31,
           64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b0);
    run_op("divuw_sext", OP_DIVU, 1'b1, 64'hABCD_0000_8000_0000, 64'hFFFF_0000_0000_0001, 6'd32,
           64'hFFFF_FFFF_8000_0000, 33, 1'b0);

    // Back-to-back: second request issued in the DONE cycle of the first
    @(negedge clk);
    start_op(OP_DIV, 1'b0, 64'd9, 64'd3, 6'd1);
    finish_op("b2b_first", 64'd3, 6'd1, 65, 1'b0);
    start_op(OP_REMU, 1'b0, 64'd100, 64'd7, 6'd2);
    finish_op("b2b_second", 64'd2, 6'd2, 65, 1'b0);

    // Flush at cycle 10 of CALC
    @(negedge clk);
    start_op(OP_DIV, 1'b0, 64'd100, 64'd7, 6'd9);
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_busy", 64'(bus.div_busy), 64'd0);
    count_done(80, dones);
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_result_held", bus.div_result, 64'd2);
    check("flush_rd_held", 64'(bus.div_rd_out), 64'd2);

    // Flush and start together: request dropped
    @(negedge clk);
    start_op(OP_DIV, 1'b0, 64'd50, 64'd5, 6'd7);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.div_start = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check("flush_start_busy", 64'(bus.div_busy), 64'd0);
    count_done(70, dones);
    check("flush_start_no_done", 64'(dones), 64'd0);

    // Reset asserted at cycle 20 of CALC
    @(negedge clk);
    start_op(OP_DIV, 1'b0, 64'd100, 64'd7, 6'd5);
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_busy",   64'(bus.div_busy),   64'd0);
    check("midrst_stall",  64'(bus.div_stall),  64'd0);
    check("midrst_done",   64'(bus.div_done),   64'd0);
    check("midrst_result", bus.div_result,      64'd0);
    check("midrst_rd_out", 64'(bus.div_rd_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    count_done(80, dones);
    check("midrst_no_done", 64'(dones), 64'd0);
    run_op("post_rst_div", OP_DIV, 1'b0, 64'd9, 64'd3, 6'd4, 64'd3, 65, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
